screen_scanout: RTL and testbench

SCREEN_SCANOUT -- requirements
Module: screen_scanout

---
 rtl/screen_scanout.sv | 140 ++++++++++++++
 tb/tb_screen_scanout.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/screen_scanout.sv
// screen_scanout: 640x480@60 VGA timing generator that scans a 512x256
// monochrome (Hack-style) frame buffer, centred in the visible area.
//
// Ports
//   clk          25 MHz pixel clock, rising edge
//   rst          synchronous, active-high reset
//   ram_addr     word address to the screen memory (registered, held between fetches)
//   ram_rdata    screen memory read data, valid one clk after ram_addr is sampled
//   vga_hs       horizontal sync, active low
//   vga_vs       vertical sync, active low
//   vga_de       display enable, high inside the 640x480 visible area
//   pixel        1 = black (frame buffer bit set), 0 = white or border
//   frame_start  one-clk pulse coincident with the output of position (0,0)
//
// Every output for counter position (h,v) appears two clocks after the
// counters hold (h,v): stage 1 decodes the counters, stage 2 drives the pins.
module screen_scanout #(
    parameter int DW = 16,
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_rdata,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_de,
    output logic          pixel,
    output logic          frame_start
);

    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] V_LAST   = 10'd524;
    localparam logic [9:0] H_VIS    = 10'd640;
    localparam logic [9:0] V_VIS    = 10'd480;
    localparam logic [9:0] HS_FIRST = 10'd656;
    localparam logic [9:0] HS_LAST  = 10'd751;
    localparam logic [9:0] VS_FIRST = 10'd490;
    localparam logic [9:0] VS_LAST  = 10'd491;
    localparam logic [9:0] WIN_X0   = 10'd64;
    localparam logic [9:0] WIN_X1   = 10'd575;
    localparam logic [9:0] WIN_Y0   = 10'd112;
    localparam logic [9:0] WIN_Y1   = 10'd367;
    // Word k is fetched at h = 48 + 16k, i.e. 16 clocks ahead of its first
    // pixel column 64 + 16k. Its data lands in next_word at h = 50 + 16k and
    // is moved into cur_word at h = 64 + 16k, before the following fetch
    // overwrites next_word at h = 66 + 16k.
    localparam logic [9:0] FETCH_H0 = 10'd48;
    localparam logic [9:0] FETCH_H1 = 10'd544;

    logic [9:0] h_cnt, v_cnt;

    // stage 1: decoded counter position
    logic       s1_hs, s1_vs, s1_de, s1_win, s1_fs;
    logic [3:0] s1_x;

    // fetch pipeline: p1 = address on ram_addr, p2 = data on ram_rdata
    logic          fetch_p1, fetch_p2;
    logic [DW-1:0] next_word, cur_word;

    // combinational decode of the current counter position
    logic        h_wrap, v_wrap, win_v, win_h, fetch_go, word_load;
    logic        hs_n, vs_n, de;
    logic [7:0]  fetch_y;
    logic [4:0]  fetch_k;
    logic [12:0] fetch_addr;

    always_comb begin
        h_wrap     = (h_cnt == H_LAST);
        v_wrap     = (v_cnt == V_LAST);
        win_v      = (v_cnt >= WIN_Y0) && (v_cnt <= WIN_Y1);
        win_h      = (h_cnt >= WIN_X0) && (h_cnt <= WIN_X1);
        hs_n       = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
        vs_n       = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
        de         = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        fetch_go   = win_v && (h_cnt >= FETCH_H0) && (h_cnt <= FETCH_H1)
                     && (h_cnt[3:0] == 4'd0);
        // window starts on a 16-column boundary, so x[3:0] == h[3:0]
        word_load  = win_v && win_h && (h_cnt[3:0] == 4'd0);
        fetch_y    = 8'(v_cnt - WIN_Y0);
        fetch_k    = 5'((h_cnt - FETCH_H0) >> 4);
        fetch_addr = {fetch_y, fetch_k};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            s1_hs       <= 1'b1;
            s1_vs       <= 1'b1;
            s1_de       <= 1'b0;
            s1_win      <= 1'b0;
            s1_fs       <= 1'b0;
            s1_x        <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_de      <= 1'b0;
            pixel       <= 1'b0;
            frame_start <= 1'b0;
            ram_addr    <= '0;
            fetch_p1    <= 1'b0;
            fetch_p2    <= 1'b0;
            next_word   <= '0;
            cur_word    <= '0;
        end else begin
            // raster counters
            h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
            if (h_wrap)
                v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;

            // stage 1
            s1_hs  <= hs_n;
            s1_vs  <= vs_n;
            s1_de  <= de;
            s1_win <= win_v && win_h;
            s1_fs  <= (h_cnt == '0) && (v_cnt == '0);
            s1_x   <= h_cnt[3:0];

            // stage 2: pins (window lies inside the visible area, so
            // s1_win already implies display enable)
            vga_hs      <= s1_hs;
            vga_vs      <= s1_vs;
            vga_de      <= s1_de;
            frame_start <= s1_fs;
            pixel       <= s1_win && s1_de && cur_word[s1_x];

            // screen memory fetch; address holds between fetches
            fetch_p1 <= fetch_go;
            fetch_p2 <= fetch_p1;
            if (fetch_go)
                ram_addr <= AW'(fetch_addr);
            // read data is only trusted in its single valid cycle
            if (fetch_p2)
                next_word <= ram_rdata;
            if (word_load)
                cur_word <= next_word;
        end
    end

endmodule

// File: tb/tb_screen_scanout.sv
// Bench for screen_scanout: synchronous RAM model, reference raster model
// computed from pixel coordinates, and a per-line fetch monitor.
module tb_screen_scanout;

    localparam int FRAME = 420000;
    localparam logic [4:0] IDLE = 5'b11000; // {hs, vs, de, pixel, frame_start}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] ram_addr;
    logic [15:0] ram_rdata = '0;
    logic        vga_hs, vga_vs, vga_de, pixel, frame_start;

    logic [15:0] mem [0:8191];

    int tests = 0;
    int fails = 0;

    int  fetch_q[$];
    bit  line_ok = 0;
    int  fs_q[$];
    int  hs_low, vs_low, de_hi, px_hi;

    screen_scanout #(.DW(16), .AW(13)) dut (
        .clk         (clk),
        .rst         (rst),
        .ram_addr    (ram_addr),
        .ram_rdata   (ram_rdata),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de),
        .pixel       (pixel),
        .frame_start (frame_start)
    );

    always #20 clk = ~clk;

    // synchronous read port: address sampled at the edge, data the next cycle
    always @(posedge clk) ram_rdata <= mem[ram_addr];

    task automatic finish_tb();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
            if (fails >= 40) finish_tb();
        end
    endtask

    function automatic logic [4:0] outs();
        return {vga_hs, vga_vs, vga_de, pixel, frame_start};
    endfunction

    // expected pins for raster position p (0 .. FRAME-1)
    function automatic logic [4:0] ref_out(input int p);
        int h = p % 800;
        int v = p / 800;
        logic hs = !(h >= 656 && h <= 751);
        logic vs = !(v == 490 || v == 491);
        logic de = (h < 640) && (v < 480);
        logic px = 1'b0;
        if (h >= 64 && h < 576 && v >= 112 && v < 368) begin
            int x = h - 64;
            int y = v - 112;
            px = mem[y * 32 + x / 16][x % 16];
        end
        return {hs, vs, de, px, (p == 0)};
    endfunction

    function automatic bit in_win_line(input int v);
        return (v >= 112) && (v < 368);
    endfunction

    // distinct addresses seen during line pv must be y*32 .. y*32+31, in
    // order, after the value held over from before the line
    task automatic eval_line(input int pv);
        if (in_win_line(pv)) begin
            int y = pv - 112;
            if (fetch_q.size() > 0 && fetch_q[0] != y * 32) void'(fetch_q.pop_front());
            chk("fetch_cnt", 32'(fetch_q.size()), 32'd32);
            for (int i = 0; i < fetch_q.size() && i < 32; i++)
                chk("fetch_addr", 32'(fetch_q[i]), 32'(y * 32 + i));
        end else begin
            chk("fetch_none", 32'(fetch_q.size()), 32'd1);
        end
    endtask

    task automatic mon_fetch(input int cp);
        int h = cp % 800;
        int v = cp / 800;
        if (h == 0) begin
            if (line_ok) eval_line(v == 0 ? 524 : v - 1);
            fetch_q.delete();
            fetch_q.push_back(int'(ram_addr));
            line_ok = 1;
        end else if (line_ok && int'(ram_addr) != fetch_q[$]) begin
            fetch_q.push_back(int'(ram_addr));
        end
        if (in_win_line(v) && h == 62)
            chk("first_fetch", 32'(ram_addr), 32'((v - 112) * 32));
    endtask

    // n = clocks since the last reset edge; sampled on the falling edge
    task automatic run_phase(input int last, input bit agg);
        for (int n = 0; n <= last; n++) begin
            logic [4:0] exp;
            if (n > 0) begin
                @(posedge clk);
                @(negedge clk);
            end
            exp = (n < 2) ? IDLE : ref_out((n - 2) % FRAME);
            chk("outs", 32'(outs()), 32'(exp));
            mon_fetch(n % FRAME);
            if (agg) begin
                if (frame_start) fs_q.push_back(n);
                if (n >= 2 && n < FRAME + 2) begin
                    hs_low += int'(!vga_hs);
                    vs_low += int'(!vga_vs);
                    de_hi  += int'(vga_de);
                    px_hi  += int'(pixel);
                end
            end
        end
    endtask

    initial begin
        int exp_px;

        // phase 1 content: alternating AAAA/5555 lines, then random lines
        for (int a = 0; a < 8192; a++) begin
            if (a / 32 < 64) mem[a] = ((a / 32) % 2 == 0) ? 16'hAAAA : 16'h5555;
            else             mem[a] = 16'($urandom);
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", 32'(outs()), 32'(IDLE));
        chk("rst_addr", 32'(ram_addr), 32'd0);

        rst = 1'b0;
        line_ok = 0;
        run_phase(200 * 800 + 300, 1'b0);   // ends with counters at (300,200)

        // mid-frame, mid-line reset for 3 clocks
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("midrst_outs", 32'(outs()), 32'(IDLE));
            chk("midrst_addr", 32'(ram_addr), 32'd0);
        end

        // phase 2 content: mostly blank, corner pixels, two random lines
        for (int a = 0; a < 8192; a++) mem[a] = 16'h0000;
        mem[0]    = 16'h0001;
        mem[8191] = 16'h8000;
        for (int a = 3200; a < 3264; a++) mem[a] = 16'($urandom);
        exp_px = 0;
        for (int a = 0; a < 8192; a++) exp_px += $countones(mem[a]);

        hs_low = 0; vs_low = 0; de_hi = 0; px_hi = 0;
        rst = 1'b0;
        line_ok = 0;
        run_phase(FRAME + 3, 1'b1);

        chk("fs_count", 32'(fs_q.size()), 32'd2);
        if (fs_q.size() >= 2) begin
            chk("fs_first", 32'(fs_q[0]), 32'd2);
            chk("fs_period", 32'(fs_q[1] - fs_q[0]), 32'(FRAME));
        end
        chk("hs_low_clks", 32'(hs_low), 32'(96 * 525));
        chk("vs_low_clks", 32'(vs_low), 32'(2 * 800));
        chk("de_clks", 32'(de_hi), 32'(640 * 480));
        chk("black_px", 32'(px_hi), 32'(exp_px));

        finish_tb();
    end

endmodule
